// File: rtl/demo_pkg.sv
// Shared constants and types for the VGA demo scene sequencer.
// The phase encoding is visible on the phase output, so downstream logic can rely on it.
package demo_pkg;

  localparam int FRAME_CNT_W = 12;
  localparam int LEVEL_W     = 8;

  localparam logic [1:0] PH_FADE_IN  = 2'd0;
  localparam logic [1:0] PH_HOLD     = 2'd1;
  localparam logic [1:0] PH_FADE_OUT = 2'd2;
  localparam logic [1:0] PH_SWITCH   = 2'd3;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  typedef enum logic [1:0] {
    ST_FADE_IN  = PH_FADE_IN,
    ST_HOLD     = PH_HOLD,
    ST_FADE_OUT = PH_FADE_OUT,
    ST_SWITCH   = PH_SWITCH
  } phase_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, frame-rate debounce, rising-edge event.
// The debounced value flips after DEBOUNCE_FRAMES consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic sample_en,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter of remaining differing samples; terminal count at zero flips the output.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    cnt_d    = cnt_q;
    btn_rise = 1'b0;
    if (sample_en) begin
      if (sync2_q != db_q) begin
        if (cnt_q == '0) begin
          db_d     = ~db_q;
          cnt_d    = CNT_RELOAD;
          btn_rise = ~db_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        cnt_d = CNT_RELOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= CNT_RELOAD;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-level scene sequencer: sync strobes, frame counter, fade envelope and scene stepping.
//   state       | meaning
//   ST_FADE_IN  | level rises by FADE_STEP per frame until 255
//   ST_HOLD     | level at 255 for HOLD_FRAMES frames
//   ST_FADE_OUT | level falls by FADE_STEP per frame until 0
//   ST_SWITCH   | advance scene, pulse scene_start, back to fade-in
module demo_scene_sequencer
  import demo_pkg::*;
#(
  parameter int NUM_SCENES      = 4,
  parameter int HOLD_FRAMES     = 240,
  parameter int FADE_STEP       = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  localparam int SCENE_W        = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   btn_next,
  input  logic                   btn_pause,
  output logic                   frame_tick,
  output logic                   line_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [SCENE_W-1:0]     scene,
  output logic [LEVEL_W-1:0]     level,
  output logic [1:0]             phase,
  output logic                   scene_start,
  output logic                   paused
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);
  localparam logic [LEVEL_W:0]   STEP       = (LEVEL_W + 1)'(FADE_STEP);

  phase_e                 state_q, state_d;
  logic                   vsync_q, vsync_d, hsync_q, hsync_d;
  logic                   frame_tick_q, frame_tick_d, line_tick_q, line_tick_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SCENE_W-1:0]     scene_q, scene_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   scene_start_q, scene_start_d;
  logic                   paused_q, paused_d;

  logic               next_evt, pause_evt, run;
  logic [LEVEL_W:0]   level_up;
  logic [LEVEL_W-1:0] level_inc, level_dec;

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_next (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_next),
    .sample_en(frame_tick_q),
    .btn_rise (next_evt)
  );

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_pause (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_pause),
    .sample_en(frame_tick_q),
    .btn_rise (pause_evt)
  );

  // Saturating envelope arithmetic: 9-bit add for fade-in, compare-before-subtract for fade-out.
  assign level_up  = {1'b0, level_q} + STEP;
  assign level_inc = level_up[LEVEL_W] ? LEVEL_MAX : level_up[LEVEL_W-1:0];
  assign level_dec = ({1'b0, level_q} <= STEP) ? '0 : level_q - STEP[LEVEL_W-1:0];

  // A pause event consumes its tick, so neither the frame nor a coincident next event advances.
  assign run = frame_tick_q & ~paused_q & ~pause_evt;

  always_comb begin
    vsync_d       = vsync;
    hsync_d       = hsync;
    frame_tick_d  = vsync & ~vsync_q;
    line_tick_d   = hsync & ~hsync_q;
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    scene_d       = scene_q;
    level_d       = level_q;
    hold_d        = hold_q;
    scene_start_d = 1'b0;
    paused_d      = paused_q;

    if (frame_tick_q && pause_evt) paused_d = ~paused_q;

    if (run) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      case (state_q)
        ST_FADE_IN: begin
          if (next_evt) begin
            state_d = ST_FADE_OUT;
          end else begin
            level_d = level_inc;
            if (level_inc == LEVEL_MAX) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end
          end
        end
        ST_HOLD: begin
          if (next_evt) begin
            state_d = ST_FADE_OUT;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_LAST) state_d = ST_FADE_OUT;
          end
        end
        ST_FADE_OUT: begin
          level_d = level_dec;
          if (level_dec == '0) state_d = ST_SWITCH;
        end
        ST_SWITCH: begin
          level_d       = '0;
          scene_d       = (scene_q == SCENE_LAST) ? '0 : scene_q + SCENE_W'(1);
          scene_start_d = 1'b1;
          state_d       = ST_FADE_IN;
        end
        default: state_d = ST_FADE_IN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FADE_IN;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      frame_tick_q  <= 1'b0;
      line_tick_q   <= 1'b0;
      frame_cnt_q   <= '0;
      scene_q       <= '0;
      level_q       <= '0;
      hold_q        <= '0;
      scene_start_q <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      frame_tick_q  <= frame_tick_d;
      line_tick_q   <= line_tick_d;
      frame_cnt_q   <= frame_cnt_d;
      scene_q       <= scene_d;
      level_q       <= level_d;
      hold_q        <= hold_d;
      scene_start_q <= scene_start_d;
      paused_q      <= paused_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign line_tick   = line_tick_q;
  assign frame_cnt   = frame_cnt_q;
  assign scene       = scene_q;
  assign level       = level_q;
  assign phase       = state_q;
  assign scene_start = scene_start_q;
  assign paused      = paused_q;

endmodule
